// File: rtl/nios_screen_reader_request_port.sv
// -----------------------------------------------------------------------------
// nios_screen_reader_request_port
//
// Receive-side Avalon-MM input port for the screen-reader request lines. The
// request lines come from fabric logic and are asynchronous to clk. This block
// synchronizes them and detects a rising edge on each line. Each edge is held
// in a sticky capture register. A level interrupt goes to the Nios while any
// captured edge is enabled in the mask.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   address     word address of the register being read or written
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous request lines (WIDTH bits)
//   readdata    read data; combinational from address, zero wait states
//   irq         level interrupt to the Nios, active-high
//
// Register map
//   0  DATA     read: synchronized in_port, zero-extended; writes ignored
//   1  -        reads 0; writes ignored
//   2  IRQMASK  read/write, bits [WIDTH-1:0]
//   3  EDGECAP  read: sticky rising edges; write 1 to clear a bit
// -----------------------------------------------------------------------------
module nios_screen_reader_request_port #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;

   logic             wr_en;
   logic             wr_mask;
   logic             wr_edgecap;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] clear;

   // Only the low WIDTH bits of writedata are used.
   logic             unused_writedata;
   assign unused_writedata = ^writedata;

   assign wr_en      = chipselect && !write_n;
   assign wr_mask    = wr_en && (address == ADDR_IRQMASK);
   assign wr_edgecap = wr_en && (address == ADDR_EDGECAP);

   assign rise  = sync2 & ~prev;
   assign clear = wr_edgecap ? writedata[WIDTH-1:0] : '0;

   // prev is cleared by reset, like sync2. A line that is already high when
   // reset is released therefore reports one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask <= '0;
      end else if (wr_mask) begin
         irqmask <= writedata[WIDTH-1:0];
      end
   end

   // If a new edge arrives in the same cycle as a clear of that bit, the edge
   // takes priority. This keeps a request from being lost while software
   // acknowledges the previous one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecap <= '0;
      end else begin
         edgecap <= rise | (edgecap & ~clear);
      end
   end

   // irq is built only from registers, so it cannot glitch on in_port.
   assign irq = |(edgecap & irqmask);

   // The read mux ignores chipselect because the fabric qualifies reads.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = sync2;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
         default:      readdata = '0;
      endcase
   end

endmodule
